text_line_ctrl: RTL and testbench

Controller that owns a small character buffer and sequences a single glyph renderer (one `text_display` instance) across a horizontal line of `NUM_CHARS` character cells. Each cycle it drives the renderer's `char_code`, `x_pos` and `y_pos` for the cell that contains the next pixel. Game logic (score, "GAME OVER", "P1 WINS") writes characters through a valid/ready port. The block also handles a buffer clear sweep and optional frame-based blinking.

---
 rtl/pong_text_pkg.sv | 17 +
 rtl/blink_timer.sv | 58 +++++
 rtl/text_line_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_text_line_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_text_pkg.sv
// Shared types and constants for the text line controller and its blink timer.
package pong_text_pkg;

  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam int         GLYPH_W     = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } text_fsm_t;

  typedef enum logic {
    VISIBLE = 1'b0,
    HIDDEN  = 1'b1
  } blink_phase_t;

endpackage

// File: rtl/blink_timer.sv
// Frame-based blink timer for the text line.
// Compiled only when TEXT_BLINK_EN is defined; the line controller instantiates
// it under the same macro.
// The phase output is the value the phase register takes at the coming edge,
// so a toggle shows up on the same edge that registers the final frame pulse.
`ifdef TEXT_BLINK_EN
module blink_timer
  import pong_text_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic         clk_0,
  input  logic         rst,
  input  logic         frame_start,
  input  logic         blink_en,
  output blink_phase_t phase
);

  localparam int            CW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  blink_phase_t  phase_q, phase_d;

  // Count frame pulses while enabled; wrap and toggle the phase on the last one.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!blink_en) begin
      cnt_d   = '0;
      phase_d = VISIBLE;
    end else if (frame_start) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        phase_d = (phase_q == VISIBLE) ? HIDDEN : VISIBLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= VISIBLE;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_d;

endmodule
`endif

// File: rtl/text_line_ctrl.sv
// Text line controller: owns an NUM_CHARS-cell character buffer, accepts
// writes over a valid/ready port, performs a clear sweep, and drives one glyph
// renderer with a one-pixel lookahead so the renderer sees the right cell.
// Optional blinking of the whole line is compiled in with TEXT_BLINK_EN.
module text_line_ctrl
  import pong_text_pkg::*;
#(
  parameter  int SCALE        = 4,
  parameter  int NUM_CHARS    = 8,
  parameter  int X0           = 192,
  parameter  int Y0           = 32,
  parameter  int BLINK_FRAMES = 30,
  localparam int IW           = $clog2(NUM_CHARS)
) (
  input  logic          clk_0,
  input  logic          rst,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          frame_start,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [IW-1:0] wr_idx,
  input  logic [6:0]    wr_char,
  input  logic          clear,
  input  logic          blink_en,
  output logic          busy,
  output logic [6:0]    char_code,
  output logic [9:0]    x_pos,
  output logic [9:0]    y_pos
);

  localparam int            CELL_W    = GLYPH_W * SCALE;
  localparam logic [9:0]    X0_V      = 10'(X0);
  localparam logic [10:0]   X_END_V   = 11'(X0 + NUM_CHARS * CELL_W);
  localparam logic [9:0]    CELL_W_V  = 10'(CELL_W);
  localparam logic [IW-1:0] LAST_SLOT = IW'(NUM_CHARS - 1);
  localparam logic [IW:0]   NUM_V     = (IW + 1)'(NUM_CHARS);

  text_fsm_t     state_q, state_d;
  logic [IW-1:0] clr_cnt_q, clr_cnt_d;
  logic          wr_ready_q, wr_ready_d;
  logic          wr_accept;
  logic [6:0]    char_buf_q [NUM_CHARS];
  logic [6:0]    char_buf_d [NUM_CHARS];
  logic [6:0]    char_code_q, char_code_d;
  logic [9:0]    x_pos_q, x_pos_d;
  logic [9:0]    nx;
  logic [9:0]    offset;
  logic [IW-1:0] slot;
  logic          in_region;
  logic          line_hidden;
  logic          unused_inputs;

  // ---------------------------------------------------------------------------
  // Blink phase (optional)
  // ---------------------------------------------------------------------------
`ifdef TEXT_BLINK_EN
  blink_phase_t phase;

  blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink_timer (
    .clk_0       (clk_0),
    .rst         (rst),
    .frame_start (frame_start),
    .blink_en    (blink_en),
    .phase       (phase)
  );

  assign line_hidden   = (phase == HIDDEN);
  assign unused_inputs = ^pixel_y;
`else
  assign line_hidden   = 1'b0;
  assign unused_inputs = ^{pixel_y, frame_start, blink_en};
`endif

  // ---------------------------------------------------------------------------
  // Control FSM: idle/write acceptance and the clear sweep
  // ---------------------------------------------------------------------------

  // Next state, sweep counter and write acceptance; a clear beats a same-cycle write.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (wr_valid && wr_ready_q) begin
          wr_accept = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == LAST_SLOT) begin
          state_d = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so that it stays low during reset and rises one clock after.
    wr_ready_d = (state_d == IDLE);
  end

  // FSM state, sweep counter and ready register.
  always_ff @(posedge clk_0 or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  assign wr_ready = wr_ready_q;
  assign busy     = (state_q == CLEAR);

  // ---------------------------------------------------------------------------
  // Character buffer
  // ---------------------------------------------------------------------------

  // Sweep writes one space per cycle; accepted writes to out-of-range cells are dropped.
  always_comb begin
    char_buf_d = char_buf_q;
    if (state_q == CLEAR) begin
      char_buf_d[clr_cnt_q] = ASCII_SPACE;
    end else if (wr_accept && ({1'b0, wr_idx} < NUM_V)) begin
      char_buf_d[wr_idx] = wr_char;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk_0 or posedge rst) begin
    // NOTE: this small buffer is flop-based and must read as all spaces the
    // moment reset asserts (even mid-sweep), so every cell is reset here; a
    // RAM-style array would normally be left without reset.
    if (rst) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        char_buf_q[i] <= ASCII_SPACE;
      end
    end else begin
      char_buf_q <= char_buf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Renderer drive with one-pixel lookahead
  // ---------------------------------------------------------------------------

  assign nx        = pixel_x + 10'd1;
  assign in_region = (nx >= X0_V) && ({1'b0, nx} < X_END_V);
  assign offset    = nx - X0_V;
  assign slot      = IW'(offset / CELL_W_V);

  // Select the cell holding the next pixel; outside the line, show a space at X0.
  always_comb begin
    char_code_d = ASCII_SPACE;
    x_pos_d     = X0_V;
    if (in_region) begin
      char_code_d = char_buf_q[slot];
      x_pos_d     = nx - (offset % CELL_W_V);
    end
    if (line_hidden) begin
      char_code_d = ASCII_SPACE;
    end
  end

  // Registered renderer drive.
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      char_code_q <= ASCII_SPACE;
      x_pos_q     <= X0_V;
    end else begin
      char_code_q <= char_code_d;
      x_pos_q     <= x_pos_d;
    end
  end

  assign char_code = char_code_q;
  assign x_pos     = x_pos_q;
  assign y_pos     = 10'(Y0);

endmodule

// File: tb/tb_text_line_ctrl.sv
// Directed self-checking bench for text_line_ctrl (SCALE=4, NUM_CHARS=8,
// X0=192, Y0=32, BLINK_FRAMES=2). Blink checks depend on TEXT_BLINK_EN.
module tb_text_line_ctrl;

  localparam int X0 = 192;
  localparam int Y0 = 32;
  localparam int CW = 32;
  localparam int NC = 8;

  logic       clk_0;
  logic       rst;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_start;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_idx;
  logic [6:0] wr_char;
  logic       clear;
  logic       blink_en;
  logic       busy;
  logic [6:0] char_code;
  logic [9:0] x_pos;
  logic [9:0] y_pos;

  int checks = 0;
  int errors = 0;

  logic [6:0] model_buf [NC];

  text_line_ctrl #(
    .SCALE        (4),
    .NUM_CHARS    (NC),
    .X0           (X0),
    .Y0           (Y0),
    .BLINK_FRAMES (2)
  ) dut (
    .clk_0       (clk_0),
    .rst         (rst),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .frame_start (frame_start),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_idx      (wr_idx),
    .wr_char     (wr_char),
    .clear       (clear),
    .blink_en    (blink_en),
    .busy        (busy),
    .char_code   (char_code),
    .x_pos       (x_pos),
    .y_pos       (y_pos)
  );

  initial clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_0);
    #1;
  endtask

  // Present pixel n-1 for one edge, so outputs now belong to pixel n.
  task automatic view(input int n);
    pixel_x = 10'(n - 1);
    tick();
    pixel_x = 10'(n);
  endtask

  task automatic write(input int idx, input logic [6:0] ch);
    wr_valid = 1'b1;
    wr_idx   = 3'(idx);
    wr_char  = ch;
    tick();
    wr_valid = 1'b0;
    model_buf[idx] = ch;
  endtask

  function automatic logic [6:0] exp_char(input int p);
    if (p >= X0 && p < X0 + NC * CW) return model_buf[(p - X0) / CW];
    return 7'h20;
  endfunction

  function automatic logic [9:0] exp_x(input int p);
    if (p >= X0 && p < X0 + NC * CW) return 10'(X0 + ((p - X0) / CW) * CW);
    return 10'(X0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NC; i++) model_buf[i] = 7'h20;
    rst = 1'b1; pixel_x = '0; pixel_y = 10'd40; frame_start = 1'b0;
    wr_valid = 1'b0; wr_idx = '0; wr_char = '0; clear = 1'b0; blink_en = 1'b0;

    // Reset state
    #1;
    check("rst_char", 16'(char_code), 16'h20);
    check("rst_x",    16'(x_pos),     16'(X0));
    check("rst_y",    16'(y_pos),     16'(Y0));
    check("rst_ready",16'(wr_ready),  16'd0);
    check("rst_busy", 16'(busy),      16'd0);
    tick();
    rst = 1'b0;
    check("ready_before_clk", 16'(wr_ready), 16'd0);
    tick();
    check("ready_after_clk", 16'(wr_ready), 16'd1);
    check("busy_idle",       16'(busy),     16'd0);

    // Write "SCORE" into slots 0..4
    write(0, 7'h53); write(1, 7'h43); write(2, 7'h4F); write(3, 7'h52); write(4, 7'h45);
    view(X0 + 32);
    check("score_c_char", 16'(char_code), 16'h43);
    check("score_c_x",    16'(x_pos),     16'(X0 + 32));
    view(X0 - 1);
    check("before_line_char", 16'(char_code), 16'h20);
    check("before_line_x",    16'(x_pos),     16'(X0));
    view(X0 + 159);
    check("score_e_char", 16'(char_code), 16'h45);
    check("score_e_x",    16'(x_pos),     16'(X0 + 128));
    view(X0 + 160);
    check("slot5_char", 16'(char_code), 16'h20);
    check("slot5_x",    16'(x_pos),     16'(X0 + 160));

    // Write-to-display latency: the edge that takes the write still shows the old value
    write(7, 7'h5A);
    pixel_x = 10'(X0 + 191);
    tick();
    wr_valid = 1'b1; wr_idx = 3'd6; wr_char = 7'h57;
    tick();
    wr_valid = 1'b0; model_buf[6] = 7'h57;
    check("lat_old", 16'(char_code), 16'h20);
    tick();
    check("lat_new", 16'(char_code), 16'h57);

    // Scan across the whole line and just past it
    pixel_x = 10'(X0 - 3);
    for (int n = X0 - 2; n <= X0 + NC * CW; n++) begin
      pixel_x = 10'(n - 1);
      tick();
      check("scan_char", 16'(char_code), 16'(exp_char(n)));
      check("scan_x",    16'(x_pos),     16'(exp_x(n)));
    end

    // Line wrap: last pixel of the line looks ahead to x=0
    pixel_x = 10'd1023;
    tick();
    check("wrap_char", 16'(char_code), 16'h20);
    check("wrap_x",    16'(x_pos),     16'(X0));

    // Clear together with a write: clear wins
    clear = 1'b1; wr_valid = 1'b1; wr_idx = 3'd5; wr_char = 7'h58;
    tick();
    clear = 1'b0; wr_valid = 1'b0;
    check("clr_busy_c1",  16'(busy),     16'd1);
    check("clr_ready_c1", 16'(wr_ready), 16'd0);
    for (int k = 2; k <= 8; k++) begin
      if (k == 4) begin
        // Re-issued clear is ignored; write to an already-cleared slot is refused
        clear = 1'b1; wr_valid = 1'b1; wr_idx = 3'd0; wr_char = 7'h4B;
      end else if (k == 5) begin
        clear = 1'b0; wr_valid = 1'b1; wr_idx = 3'd7; wr_char = 7'h51;
      end else begin
        clear = 1'b0; wr_valid = 1'b0;
      end
      tick();
      check("clr_busy_mid",  16'(busy),     16'd1);
      check("clr_ready_mid", 16'(wr_ready), 16'd0);
    end
    tick();
    check("clr_busy_c9",  16'(busy),     16'd0);
    check("clr_ready_c9", 16'(wr_ready), 16'd1);
    for (int i = 0; i < NC; i++) model_buf[i] = 7'h20;
    for (int s = 0; s < NC; s++) begin
      view(X0 + s * CW + 5);
      check("cleared_slot", 16'(char_code), 16'h20);
    end

    // Blink behaviour
    write(0, 7'h41);
    pixel_x = 10'(X0 - 1);
    blink_en = 1'b1;
    tick();
    check("blink_base", 16'(char_code), 16'h41);
`ifdef TEXT_BLINK_EN
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("blink_f1", 16'(char_code), 16'h41);
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("blink_f2_hidden", 16'(char_code), 16'h20);
    tick();
    check("blink_hold_hidden", 16'(char_code), 16'h20);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("blink_f3_hidden", 16'(char_code), 16'h20);
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("blink_f4_visible", 16'(char_code), 16'h41);
    frame_start = 1'b1; tick();
    tick(); frame_start = 1'b0;
    check("blink_f6_hidden", 16'(char_code), 16'h20);
    blink_en = 1'b0;
    tick();
    check("blink_off_visible", 16'(char_code), 16'h41);
`else
    for (int f = 0; f < 4; f++) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      check("noblink_visible", 16'(char_code), 16'h41);
      tick();
    end
    blink_en = 1'b0;
`endif

    // Reset asserted in the middle of a sweep
    write(3, 7'h44);
    pixel_x = 10'(X0 + 95);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check("pre_rst_char", 16'(char_code), 16'h44);
    check("pre_rst_x",    16'(x_pos),     16'(X0 + 96));
    check("pre_rst_busy", 16'(busy),      16'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_char",  16'(char_code), 16'h20);
    check("mid_rst_x",     16'(x_pos),     16'(X0));
    check("mid_rst_ready", 16'(wr_ready),  16'd0);
    check("mid_rst_busy",  16'(busy),      16'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", 16'(wr_ready),  16'd1);
    check("post_rst_busy",  16'(busy),      16'd0);
    check("post_rst_char",  16'(char_code), 16'h20);
    check("post_rst_x",     16'(x_pos),     16'(X0 + 96));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
